sap_microsequencer: RTL and testbench
=====================================

// Module: sap_microsequencer
// PURPOSE
//  Parametrised successor to the SAP-1 controller. It adds variable-length instructions (early return to fetch),
//  an extended ISA (STA/LDI/JMP/JC/JZ/OUT), a sticky halt, and run/single-step control.
//  Sits between the IR opcode and flag register and the datapath; drives one control word per cycle.
//  Control word = combinational decode of the registered state, current opcode and flags; no extra pipeline lag.
// PARAMETERS
//  OPCODE_W    4   opcode width; opcodes with any bit above [3:0] set are undefined
//  CTRL_W      16  control word width (>=16); bits [CTRL_W-1:16] always 0
//  UNDEF_HALT  0   1: undefined opcode behaves as HLT; 0: undefined opcode is a 3-cycle NOP
// PORTS
//  clk         in   1         clock, rising edge
//  rst_n       in   1         asynchronous reset, active-low
//  opcode      in   OPCODE_W  IR opcode field; stable from T3 on
//  flag_c      in   1         carry flag (registered in datapath)
//  flag_z      in   1         zero flag (registered in datapath)
//  run         in   1         1 = free-run; 0 = stop at the next instruction boundary
//  step_req    in   1         1-cycle pulse: execute one instruction while idle
//  ctrl        out  CTRL_W    control word: 15 OUT_LOAD,14 FLAGS_LOAD,13 PC_LOAD,12 MEM_WE,11 HLT,10 PC_INC,
//                             9 PC_EN,8 MAR_LOAD,7 MEM_EN,6 IR_LOAD,5 IR_EN,4 A_LOAD,3 A_EN,2 B_LOAD,1 SUB,0 ADDER_EN
//  stage       out  3         current T-state index (0 in IDLE/HALT)
//  instr_done  out  1         high during the last T-state of an instruction
//  idle        out  1         state == IDLE
//  halted      out  1         state == HALT
// BEHAVIOUR
//  States: IDLE, T0..T5, HALT. Async reset -> IDLE; ctrl=0, stage=0, instr_done=0, idle=1, halted=0.
//  IDLE: ctrl=0. Next cycle -> T0 if run=1 or step_req=1, otherwise stay in IDLE.
//  Fetch: T0 PC_EN|MAR_LOAD; T1 PC_INC; T2 MEM_EN|IR_LOAD. Opcode is not sampled before T3.
//  Execute (T3/T4/T5; the last listed step sets instr_done):
//   LDA 0: IR_EN|MAR_LOAD ; MEM_EN|A_LOAD
//   ADD 1: IR_EN|MAR_LOAD ; MEM_EN|B_LOAD ; ADDER_EN|A_LOAD|FLAGS_LOAD
//   SUB 2: as ADD, with SUB also set in T5
//   STA 3: IR_EN|MAR_LOAD ; A_EN|MEM_WE
//   LDI 4: IR_EN|A_LOAD
//   JMP 5: IR_EN|PC_LOAD
//   JC 6 / JZ 7: IR_EN|PC_LOAD if flag_c / flag_z (sampled combinationally in T3), else ctrl=0; length 4 either way
//   OUT 14: A_EN|OUT_LOAD
//   HLT 15: T3 ctrl=HLT only -> HALT
//   other, UNDEF_HALT=0: T2 sets instr_done; 3-cycle NOP
//   other, UNDEF_HALT=1: treated as HLT
//  From the instr_done cycle: next state = T0 if run=1, IDLE otherwise. step_req ignored outside IDLE.
//  run dropped mid-instruction: the instruction completes, then IDLE. Never abandons partway.
//  HALT: ctrl = HLT bit only; halted=1; stage=0. Left only by rst_n. run and step_req ignored.
//  Reset mid-instruction: async, immediate -> IDLE; ctrl=0 in the same cycle.
//  Instruction lengths (cycles): LDA/STA 5, ADD/SUB 6, LDI/JMP/JC/JZ/OUT 4, NOP 3.
//  No ctrl bit outside this table is ever set. At most one bus driver (*_EN) is active per cycle.
// TESTING
//  1 Reset, run=1, opcode=0 (LDA): ctrl 0x000 (IDLE), then 0x300, 0x400, 0x0C0, 0x120, 0x090,
//    then 0x300 again; instr_done only in T4.
//  2 ADD then SUB, run=1: T5 ctrl = 0x4011 for ADD and 0x4013 for SUB; 6 cycles each; T0 follows T5.
//  3 JC with flag_c=1 -> T3 ctrl=0x2020; with flag_c=0 -> T3 ctrl=0x0000. Both return to T0 next cycle.
//    Repeat both for JZ/flag_z.
//  4 HLT: T3 ctrl=0x800, halted=1 from the next cycle. Hold 20 cycles with run/step_req toggling:
//    ctrl stays 0x800. rst_n low -> IDLE.
//  5 run=0, step_req pulse in IDLE: exactly one LDI runs (T0-T3), then IDLE; a step_req mid-instruction
//    has no effect.
//  6 rst_n low during T4 of ADD: ctrl=0 and idle=1 asynchronously. Opcode 0x8 with UNDEF_HALT=0 ->
//    3-cycle NOP; with UNDEF_HALT=1 -> HALT.

Source files
------------

// File: rtl/sap_microsequencer_if.sv
// Bus between the SAP microsequencer and its datapath.
// Inputs to the sequencer: the IR opcode field, the registered carry and zero flags, and the
// run/single-step controls. Outputs from the sequencer: the control word, the T-state index and
// the status strobes.
//   master : sequencer side (drives ctrl/stage/instr_done/idle/halted)
//   slave  : datapath/front-panel side (drives opcode/flags/run/step_req)
interface sap_microsequencer_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CTRL_W   = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                flag_c;
  logic                flag_z;
  logic                run;
  logic                step_req;
  logic [CTRL_W-1:0]   ctrl;
  logic [2:0]          stage;
  logic                instr_done;
  logic                idle;
  logic                halted;

  modport master (
    input  opcode, flag_c, flag_z, run, step_req,
    output ctrl, stage, instr_done, idle, halted
  );

  modport slave (
    output opcode, flag_c, flag_z, run, step_req,
    input  ctrl, stage, instr_done, idle, halted
  );
endinterface

// File: rtl/sap_microsequencer.sv
// SAP-1 style microsequencer with variable-length instructions, an extended ISA
// (LDA/ADD/SUB/STA/LDI/JMP/JC/JZ/OUT/HLT), a sticky halt and run/single-step control.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low (returns to IDLE immediately)
//   bus   : sequencer side of sap_microsequencer_if (opcode/flags/run/step_req in,
//           ctrl/stage/instr_done/idle/halted out)
// The control word is a combinational decode of the registered T-state, the opcode and the flags,
// so it takes effect in the same cycle as the state it belongs to.
module sap_microsequencer #(
  parameter int unsigned OPCODE_W   = 4,
  parameter int unsigned CTRL_W     = 16,
  parameter bit          UNDEF_HALT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sap_microsequencer_if.master      bus
);

  // Control word bit positions.
  localparam logic [15:0] OutLoad   = 16'h8000;
  localparam logic [15:0] FlagsLoad = 16'h4000;
  localparam logic [15:0] PcLoad    = 16'h2000;
  localparam logic [15:0] MemWe     = 16'h1000;
  localparam logic [15:0] Hlt       = 16'h0800;
  localparam logic [15:0] PcInc     = 16'h0400;
  localparam logic [15:0] PcEn      = 16'h0200;
  localparam logic [15:0] MarLoad   = 16'h0100;
  localparam logic [15:0] MemEn     = 16'h0080;
  localparam logic [15:0] IrLoad    = 16'h0040;
  localparam logic [15:0] IrEn      = 16'h0020;
  localparam logic [15:0] ALoad     = 16'h0010;
  localparam logic [15:0] AEn       = 16'h0008;
  localparam logic [15:0] BLoad     = 16'h0004;
  localparam logic [15:0] Sub       = 16'h0002;
  localparam logic [15:0] AdderEn   = 16'h0001;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StHalt
  } state_e;

  state_e state_q, state_d;

  logic [OPCODE_W-1:0] op_full;
  logic [3:0]          op_lo;
  logic                op_undef;
  logic                is_nop;
  logic [3:0]          eff_op;
  logic [15:0]         cw;
  logic                done;
  logic [2:0]          stage;

  // Opcode classification. Anything with a bit above [3:0] set, or 8..13, is undefined.
  always_comb begin
    op_full  = bus.opcode;
    op_lo    = op_full[3:0];
    op_undef = ((op_full >> 4) != '0) || ((op_lo >= 4'd8) && (op_lo <= 4'd13));
    is_nop   = op_undef && !UNDEF_HALT;
    // Undefined opcodes alias to HLT when UNDEF_HALT is set.
    eff_op   = (op_undef && UNDEF_HALT) ? 4'hF : op_lo;
  end

  always_comb begin
    state_d = state_q;
    cw      = '0;
    done    = 1'b0;
    stage   = 3'd0;

    unique case (state_q)
      StIdle: begin
        if (bus.run || bus.step_req) state_d = StT0;
      end
      StT0: begin
        stage   = 3'd0;
        cw      = PcEn | MarLoad;
        state_d = StT1;
      end
      StT1: begin
        stage   = 3'd1;
        cw      = PcInc;
        state_d = StT2;
      end
      StT2: begin
        stage = 3'd2;
        cw    = MemEn | IrLoad;
        // Undefined-as-NOP ends the instruction after fetch.
        if (is_nop) done = 1'b1;
        else        state_d = StT3;
      end
      StT3: begin
        stage   = 3'd3;
        state_d = StT4;
        unique case (eff_op)
          4'h0, 4'h1, 4'h2, 4'h3: cw = IrEn | MarLoad;
          4'h4: begin cw = IrEn | ALoad;   done = 1'b1; end
          4'h5: begin cw = IrEn | PcLoad;  done = 1'b1; end
          4'h6: begin cw = bus.flag_c ? (IrEn | PcLoad) : 16'h0000; done = 1'b1; end
          4'h7: begin cw = bus.flag_z ? (IrEn | PcLoad) : 16'h0000; done = 1'b1; end
          4'hE: begin cw = AEn | OutLoad;  done = 1'b1; end
          4'hF: begin cw = Hlt;            state_d = StHalt; end
          // Only reachable for NOP opcodes, which already finished in T2.
          default: done = 1'b1;
        endcase
      end
      StT4: begin
        stage   = 3'd4;
        state_d = StT5;
        unique case (eff_op)
          4'h0:       begin cw = MemEn | ALoad;  done = 1'b1; end
          4'h1, 4'h2: cw = MemEn | BLoad;
          4'h3:       begin cw = AEn | MemWe;    done = 1'b1; end
          default:    done = 1'b1;
        endcase
      end
      StT5: begin
        stage = 3'd5;
        done  = 1'b1;
        if (eff_op == 4'h1)      cw = AdderEn | ALoad | FlagsLoad;
        else if (eff_op == 4'h2) cw = AdderEn | ALoad | FlagsLoad | Sub;
        else                     cw = '0;
      end
      StHalt: begin
        cw = Hlt;
      end
      default: state_d = StIdle;
    endcase

    // Instruction boundary: continue only while run is held.
    if (done) state_d = bus.run ? StT0 : StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    bus.ctrl       = CTRL_W'(cw);
    bus.stage      = stage;
    bus.instr_done = done;
    bus.idle       = (state_q == StIdle);
    bus.halted     = (state_q == StHalt);
  end

endmodule

// File: tb/tb_sap_microsequencer.sv
module tb_sap_microsequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       flag_c, flag_z, run, step_req;
  int         checks = 0;
  int         errors = 0;

  sap_microsequencer_if #(.OPCODE_W(4), .CTRL_W(16)) u_if0 ();
  sap_microsequencer_if #(.OPCODE_W(4), .CTRL_W(16)) u_if1 ();

  assign u_if0.opcode   = opcode;
  assign u_if0.flag_c   = flag_c;
  assign u_if0.flag_z   = flag_z;
  assign u_if0.run      = run;
  assign u_if0.step_req = step_req;
  assign u_if1.opcode   = opcode;
  assign u_if1.flag_c   = flag_c;
  assign u_if1.flag_z   = flag_z;
  assign u_if1.run      = run;
  assign u_if1.step_req = step_req;

  sap_microsequencer #(.OPCODE_W(4), .CTRL_W(16), .UNDEF_HALT(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if0)
  );

  sap_microsequencer #(.OPCODE_W(4), .CTRL_W(16), .UNDEF_HALT(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1)
  );

  always #5 clk = ~clk;

  // Leaves the bench at a falling edge with both DUTs in IDLE.
  task automatic do_reset();
    rst_n    = 1'b0;
    step_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; step_req = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    #1;
    checks++; if (u_if0.ctrl !== 16'h0000) begin errors++;
      $display("FAIL reset_ctrl got %h want 0000", u_if0.ctrl); end
    checks++; if (u_if0.idle !== 1'b1) begin errors++;
      $display("FAIL reset_idle got %b want 1", u_if0.idle); end
    checks++; if (u_if0.halted !== 1'b0) begin errors++;
      $display("FAIL reset_halted got %b want 0", u_if0.halted); end
    checks++; if (u_if0.stage !== 3'd0) begin errors++;
      $display("FAIL reset_stage got %0d want 0", u_if0.stage); end
    checks++; if (u_if0.instr_done !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b want 0", u_if0.instr_done); end
  endtask

  task automatic test_lda();
    logic [15:0] exp [6];
    exp = '{16'h0300, 16'h0400, 16'h00C0, 16'h0120, 16'h0090, 16'h0300};
    opcode = 4'h0; run = 1'b1;
    do_reset();
    checks++; if (u_if0.ctrl !== 16'h0000 || u_if0.idle !== 1'b1) begin errors++;
      $display("FAIL lda_idle got ctrl=%h idle=%b want 0000/1", u_if0.ctrl, u_if0.idle); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (u_if0.ctrl !== exp[i]) begin errors++;
        $display("FAIL lda_ctrl[%0d] got %h want %h", i, u_if0.ctrl, exp[i]); end
      checks++; if (u_if0.instr_done !== (i == 4)) begin errors++;
        $display("FAIL lda_done[%0d] got %b want %b", i, u_if0.instr_done, i == 4); end
    end
  endtask

  task automatic test_add_sub();
    logic [15:0] exp [13];
    logic [2:0]  stg [13];
    exp = '{16'h0300, 16'h0400, 16'h00C0, 16'h0120, 16'h0084, 16'h4011,
            16'h0300, 16'h0400, 16'h00C0, 16'h0120, 16'h0084, 16'h4013, 16'h0000};
    stg = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    opcode = 4'h1; run = 1'b1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++; if (u_if0.ctrl !== exp[i] || u_if0.stage !== stg[i]) begin errors++;
        $display("FAIL addsub_ctrl[%0d] got %h/%0d want %h/%0d", i, u_if0.ctrl, u_if0.stage,
                 exp[i], stg[i]); end
      if (i == 6) opcode = 4'h2;
      // Dropping run mid-instruction must let SUB finish, then park in IDLE.
      if (i == 10) run = 1'b0;
    end
    checks++; if (u_if0.idle !== 1'b1) begin errors++;
      $display("FAIL addsub_idle got %b want 1", u_if0.idle); end
  endtask

  task automatic test_jumps();
    logic [3:0]  ops [4];
    logic        fc [4];
    logic        fz [4];
    logic [15:0] exp [4];
    ops = '{4'h6, 4'h6, 4'h7, 4'h7};
    fc  = '{1'b1, 1'b0, 1'b0, 1'b1};
    fz  = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp = '{16'h2020, 16'h0000, 16'h2020, 16'h0000};
    run = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k]; flag_c = fc[k]; flag_z = fz[k];
      @(negedge clk);
      checks++; if (u_if0.ctrl !== 16'h0300 || u_if0.stage !== 3'd0) begin errors++;
        $display("FAIL jump_t0[%0d] got %h/%0d want 0300/0", k, u_if0.ctrl, u_if0.stage); end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++; if (u_if0.ctrl !== exp[k] || u_if0.instr_done !== 1'b1) begin errors++;
        $display("FAIL jump_t3[%0d] got %h/%b want %h/1", k, u_if0.ctrl, u_if0.instr_done,
                 exp[k]); end
    end
    @(negedge clk);
    checks++; if (u_if0.ctrl !== 16'h0300 || u_if0.stage !== 3'd0) begin errors++;
      $display("FAIL jump_return got %h/%0d want 0300/0", u_if0.ctrl, u_if0.stage); end
    flag_c = 1'b0; flag_z = 1'b0;
  endtask

  task automatic test_hlt();
    opcode = 4'hF; run = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (u_if0.ctrl !== 16'h0800 || u_if0.halted !== 1'b0) begin errors++;
      $display("FAIL hlt_t3 got %h/%b want 0800/0", u_if0.ctrl, u_if0.halted); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (u_if0.ctrl !== 16'h0800 || u_if0.halted !== 1'b1 || u_if0.stage !== 3'd0)
      begin errors++;
        $display("FAIL hlt_hold[%0d] got %h/%b/%0d want 0800/1/0", i, u_if0.ctrl, u_if0.halted,
                 u_if0.stage); end
      run      = i[0];
      step_req = i[1];
    end
    step_req = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (u_if0.idle !== 1'b1 || u_if0.ctrl !== 16'h0000 || u_if0.halted !== 1'b0)
    begin errors++;
      $display("FAIL hlt_reset got idle=%b ctrl=%h halted=%b want 1/0000/0", u_if0.idle,
               u_if0.ctrl, u_if0.halted); end
  endtask

  task automatic test_step();
    logic [15:0] exp [7];
    exp = '{16'h0300, 16'h0400, 16'h00C0, 16'h0030, 16'h0000, 16'h0000, 16'h0000};
    opcode = 4'h4; run = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    checks++; if (u_if0.idle !== 1'b1) begin errors++;
      $display("FAIL step_wait_idle got %b want 1", u_if0.idle); end
    step_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      // Second pulse lands in T1 and must be ignored.
      step_req = (i == 1);
      checks++; if (u_if0.ctrl !== exp[i] || u_if0.idle !== (i >= 4)) begin errors++;
        $display("FAIL step_seq[%0d] got %h/%b want %h/%b", i, u_if0.ctrl, u_if0.idle, exp[i],
                 i >= 4); end
    end
  endtask

  task automatic test_async_reset();
    opcode = 4'h1; run = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    checks++; if (u_if0.ctrl !== 16'h0084) begin errors++;
      $display("FAIL areset_t4 got %h want 0084", u_if0.ctrl); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (u_if0.ctrl !== 16'h0000 || u_if0.idle !== 1'b1 || u_if0.stage !== 3'd0)
    begin errors++;
      $display("FAIL areset_now got %h/%b/%0d want 0000/1/0", u_if0.ctrl, u_if0.idle,
               u_if0.stage); end
  endtask

  task automatic test_undef();
    logic [15:0] exp0 [5];
    logic        done0 [5];
    logic [15:0] exp1 [5];
    logic        halt1 [5];
    exp0  = '{16'h0300, 16'h0400, 16'h00C0, 16'h0300, 16'h0400};
    done0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp1  = '{16'h0300, 16'h0400, 16'h00C0, 16'h0800, 16'h0800};
    halt1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 4'h8; run = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (u_if0.ctrl !== exp0[i] || u_if0.instr_done !== done0[i]) begin errors++;
        $display("FAIL undef_nop[%0d] got %h/%b want %h/%b", i, u_if0.ctrl, u_if0.instr_done,
                 exp0[i], done0[i]); end
      checks++; if (u_if1.ctrl !== exp1[i] || u_if1.halted !== halt1[i]) begin errors++;
        $display("FAIL undef_halt[%0d] got %h/%b want %h/%b", i, u_if1.ctrl, u_if1.halted,
                 exp1[i], halt1[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_jumps();
    test_hlt();
    test_step();
    test_async_reset();
    test_undef();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
